// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   REG_ADDR_W     : register-file address width
//   MC_TIMEOUT_DEF : default cycle limit for a multi-cycle operation
//   state_t        : controller FSM encoding (RUN / MC_WAIT / MEM_WAIT)
package pipe_ctrl_pkg;
   localparam int REG_ADDR_W     = 5;
   localparam int MC_TIMEOUT_DEF = 64;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MC_WAIT  = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
//   master : pipeline side (drives ID/EXE/MEM status, receives stall/flush)
//   slave  : controller side
interface pipe_hazard_ctrl_if;
   import pipe_ctrl_pkg::*;

   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  exe_valid;
   logic [REG_ADDR_W-1:0] exe_rd;
   logic                  exe_is_load;
   logic                  exe_mc_start;
   logic                  mc_done;
   logic                  mem_req;
   logic                  mem_ack;
   logic                  redirect;
   logic                  if_stall;
   logic                  id_stall;
   logic                  exe_stall;
   logic                  id_flush;
   logic                  exe_flush;
   state_t                state;
   logic                  mc_timeout;

   modport master (
      output id_valid, id_rs1, id_rs2, exe_valid, exe_rd, exe_is_load,
             exe_mc_start, mc_done, mem_req, mem_ack, redirect,
      input  if_stall, id_stall, exe_stall, id_flush, exe_flush, state, mc_timeout
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, exe_valid, exe_rd, exe_is_load,
             exe_mc_start, mc_done, mem_req, mem_ack, redirect,
      output if_stall, id_stall, exe_stall, id_flush, exe_flush, state, mc_timeout
   );
endinterface

// File: rtl/pipe_hazard_ctrl_det.sv
// Load-use hazard comparator (purely combinational).
//   id_valid/id_rs1/id_rs2        : instruction in ID and its sources
//   exe_valid/exe_rd/exe_is_load  : instruction in EXE
//   load_use                      : ID consumes a register a load in EXE writes
module pipe_hazard_det
   import pipe_ctrl_pkg::*;
(
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  exe_valid,
   input  logic [REG_ADDR_W-1:0] exe_rd,
   input  logic                  exe_is_load,
   output logic                  load_use
);
   // x0 is hardwired zero, so a load targeting it never creates a dependency
   assign load_use = id_valid & exe_valid & exe_is_load & (exe_rd != '0) &
                     ((exe_rd == id_rs1) | (exe_rd == id_rs2));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, multi-cycle (mul/div) wait
// with timeout, data-memory wait, and branch-redirect flushes.
//   clk, rst : clock, synchronous active-low reset
//   bus      : pipe_hazard_ctrl_if.slave (hazard inputs, stall/flush/state out)
//   perf_stall_cnt, perf_flush_cnt : only when PIPE_CTRL_PERF_EN is defined;
//              count cycles with if_stall=1 / exe_flush=1, wrapping.
// Optional feature macro: PIPE_CTRL_PERF_EN
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MC_TIMEOUT = MC_TIMEOUT_DEF,
   parameter int PERF_W     = 32
)(
   input  logic              clk,
   input  logic              rst,
`ifdef PIPE_CTRL_PERF_EN
   output logic [PERF_W-1:0] perf_stall_cnt,
   output logic [PERF_W-1:0] perf_flush_cnt,
`endif
   pipe_hazard_ctrl_if.slave bus
);
   localparam int             CNT_W    = $clog2(MC_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

   if (MC_TIMEOUT < 1 || PERF_W < 1) begin : g_cfg_chk
      $error("pipe_hazard_ctrl: MC_TIMEOUT and PERF_W must be >= 1");
   end

   state_t           state_q, state_d;
   logic [CNT_W-1:0] mc_cnt;
   logic             redirect_pend;
   logic             load_use;
   logic             mem_stall, mc_stall, mc_to_hit, stall_all, flush_req;
   logic             if_stall, id_stall, exe_stall, id_flush, exe_flush;

   pipe_hazard_det u_det (
      .id_valid    (bus.id_valid),
      .id_rs1      (bus.id_rs1),
      .id_rs2      (bus.id_rs2),
      .exe_valid   (bus.exe_valid),
      .exe_rd      (bus.exe_rd),
      .exe_is_load (bus.exe_is_load),
      .load_use    (load_use)
   );

   always_comb begin
      mem_stall = bus.mem_req & ~bus.mem_ack;
      mc_to_hit = (state_q == MC_WAIT) & ~bus.mc_done & (mc_cnt == CNT_LAST);
      // RUN: op just issued; MC_WAIT: still waiting and not yet timed out
      mc_stall  = ((state_q == RUN) & bus.exe_valid & bus.exe_mc_start & ~bus.mc_done) |
                  ((state_q == MC_WAIT) & ~bus.mc_done & ~mc_to_hit);
      stall_all = mem_stall | mc_stall;
      flush_req = bus.redirect | redirect_pend;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:      if (mem_stall) state_d = MEM_WAIT;
                   else if (mc_stall) state_d = MC_WAIT;
         MC_WAIT:  if (mem_stall) state_d = MEM_WAIT;
                   else if (!mc_stall) state_d = RUN;
         MEM_WAIT: if (!mem_stall) state_d = RUN;
         default:  state_d = RUN;
      endcase
   end

   // Priority: memory/multi-cycle stall > redirect flush > load-use bubble.
   // A stalled register is never flushed at the same time.
   always_comb begin
      if_stall  = 1'b0;
      id_stall  = 1'b0;
      exe_stall = 1'b0;
      id_flush  = 1'b0;
      exe_flush = 1'b0;
      if (!rst) begin
         id_flush  = 1'b1;
         exe_flush = 1'b1;
      end else if (stall_all) begin
         if_stall  = 1'b1;
         id_stall  = 1'b1;
         exe_stall = 1'b1;
      end else if (flush_req) begin
         id_flush  = 1'b1;
         exe_flush = 1'b1;
      end else if (load_use) begin
         if_stall  = 1'b1;
         id_stall  = 1'b1;
         exe_flush = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= RUN;
         mc_cnt        <= '0;
         redirect_pend <= 1'b0;
      end else begin
         state_q       <= state_d;
         // counts only while remaining in MC_WAIT, so every entry starts at 0
         mc_cnt        <= (state_q == MC_WAIT && state_d == MC_WAIT) ? mc_cnt + CNT_W'(1) : '0;
         // a redirect seen under stall is held until the first unstalled cycle
         redirect_pend <= stall_all & flush_req;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (if_stall)  perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
         if (exe_flush) perf_flush_cnt <= perf_flush_cnt + PERF_W'(1);
      end
   end
`endif

   assign bus.if_stall   = if_stall;
   assign bus.id_stall   = id_stall;
   assign bus.exe_stall  = exe_stall;
   assign bus.id_flush   = id_flush;
   assign bus.exe_flush  = exe_flush;
   assign bus.state      = state_q;
   assign bus.mc_timeout = rst & mc_to_hit;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Two instances share one stimulus:
// u_dut (default MC_TIMEOUT) and u_dut_to (MC_TIMEOUT=8) for the timeout case.
// Output vector o = {if_stall, id_stall, exe_stall, id_flush, exe_flush}.
module tb_pipe_hazard_ctrl;
   import pipe_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if bus ();
   pipe_hazard_ctrl_if bus_to ();

   assign bus_to.id_valid     = bus.id_valid;
   assign bus_to.id_rs1       = bus.id_rs1;
   assign bus_to.id_rs2       = bus.id_rs2;
   assign bus_to.exe_valid    = bus.exe_valid;
   assign bus_to.exe_rd       = bus.exe_rd;
   assign bus_to.exe_is_load  = bus.exe_is_load;
   assign bus_to.exe_mc_start = bus.exe_mc_start;
   assign bus_to.mc_done      = bus.mc_done;
   assign bus_to.mem_req      = bus.mem_req;
   assign bus_to.mem_ack      = bus.mem_ack;
   assign bus_to.redirect     = bus.redirect;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_s, perf_f, perf_s_to, perf_f_to;
`endif

   pipe_hazard_ctrl u_dut (
      .clk            (clk),
      .rst            (rst),
`ifdef PIPE_CTRL_PERF_EN
      .perf_stall_cnt (perf_s),
      .perf_flush_cnt (perf_f),
`endif
      .bus            (bus)
   );

   pipe_hazard_ctrl #(.MC_TIMEOUT(8)) u_dut_to (
      .clk            (clk),
      .rst            (rst),
`ifdef PIPE_CTRL_PERF_EN
      .perf_stall_cnt (perf_s_to),
      .perf_flush_cnt (perf_f_to),
`endif
      .bus            (bus_to)
   );

   logic [4:0] o, o_to;
   assign o    = {bus.if_stall, bus.id_stall, bus.exe_stall, bus.id_flush, bus.exe_flush};
   assign o_to = {bus_to.if_stall, bus_to.id_stall, bus_to.exe_stall, bus_to.id_flush, bus_to.exe_flush};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      bus.id_valid     = 1'b0;
      bus.id_rs1       = '0;
      bus.id_rs2       = '0;
      bus.exe_valid    = 1'b0;
      bus.exe_rd       = '0;
      bus.exe_is_load  = 1'b0;
      bus.exe_mc_start = 1'b0;
      bus.mc_done      = 1'b0;
      bus.mem_req      = 1'b0;
      bus.mem_ack      = 1'b0;
      bus.redirect     = 1'b0;
   endtask

   task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      bus.id_valid    = 1'b1;
      bus.id_rs1      = rs1;
      bus.id_rs2      = rs2;
      bus.exe_valid   = 1'b1;
      bus.exe_rd      = rd;
      bus.exe_is_load = 1'b1;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      rst = 1'b0;
      nxt(); nxt();
      smp(); chk("rst_outs", o, 5'b00011); chk("rst_state", bus.state, 0);
      chk("rst_to", bus.mc_timeout, 0);

      nxt(); rst = 1'b1;
      smp(); chk("idle_outs", o, 5'b00000);

      // load-use on rs2
      nxt(); load_use(5'd5, 5'd3, 5'd5);
      smp(); chk("lu_rs2_outs", o, 5'b11001); chk("lu_rs2_state", bus.state, 0);
      nxt(); idle();
      smp(); chk("lu_once_outs", o, 5'b00000); chk("lu_once_state", bus.state, 0);
      // load-use on rs1
      nxt(); load_use(5'd7, 5'd7, 5'd0);
      smp(); chk("lu_rs1_outs", o, 5'b11001);
      // x0 never hazards
      nxt(); load_use(5'd0, 5'd0, 5'd0);
      smp(); chk("lu_x0_outs", o, 5'b00000);
      // non-load producer
      nxt(); load_use(5'd5, 5'd5, 5'd0); bus.exe_is_load = 1'b0;
      smp(); chk("lu_noload_outs", o, 5'b00000);

      // mul: stalls 10 cycles, mc_done on the 11th
      nxt(); idle(); bus.exe_valid = 1'b1; bus.exe_mc_start = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         smp();
         chk($sformatf("mul_outs_%0d", k), o, 5'b11100);
         chk($sformatf("mul_state_%0d", k), bus.state, (k == 1) ? 0 : 1);
         nxt();
      end
      bus.mc_done = 1'b1;
      smp(); chk("mul_done_outs", o, 5'b00000); chk("mul_done_state", bus.state, 1);
      nxt(); idle();
      smp(); chk("mul_after_state", bus.state, 0); chk("mul_after_outs", o, 5'b00000);

      // timeout with MC_TIMEOUT=8: pulse on 8th MC_WAIT cycle (overall cycle 9)
      nxt(); bus.exe_valid = 1'b1; bus.exe_mc_start = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         smp();
         chk($sformatf("to_pulse_%0d", k), bus_to.mc_timeout, (k == 9) ? 1 : 0);
         chk($sformatf("to_outs_%0d", k), o_to, (k == 9) ? 5'b00000 : 5'b11100);
         chk($sformatf("to_state_%0d", k), bus_to.state, (k == 1) ? 0 : 1);
         nxt();
      end
      idle(); bus.mc_done = 1'b1;  // also releases the long-timeout instance
      smp(); chk("to_after_state", bus_to.state, 0); chk("to_after_pulse", bus_to.mc_timeout, 0);
      chk("to_main_rel", o, 5'b00000);
      nxt(); idle();
      smp(); chk("to_main_state", bus.state, 0);

      // redirect, alone and over a load-use
      nxt(); bus.redirect = 1'b1;
      smp(); chk("redir_outs", o, 5'b00011);
      nxt(); load_use(5'd5, 5'd5, 5'd0);
      smp(); chk("redir_lu_outs", o, 5'b00011);
      nxt(); idle();
      smp(); chk("redir_once_outs", o, 5'b00000);

      // redirect during memory wait, ack after 3 stalled cycles
      nxt(); bus.mem_req = 1'b1; bus.redirect = 1'b1;
      smp(); chk("mr_a_outs", o, 5'b11100); chk("mr_a_state", bus.state, 0);
      nxt(); bus.redirect = 1'b0;
      smp(); chk("mr_b_outs", o, 5'b11100); chk("mr_b_state", bus.state, 2);
      nxt();
      smp(); chk("mr_c_outs", o, 5'b11100); chk("mr_c_state", bus.state, 2);
      nxt(); bus.mem_ack = 1'b1;
      smp(); chk("mr_ack_outs", o, 5'b00011); chk("mr_ack_state", bus.state, 2);
      nxt(); idle();
      smp(); chk("mr_after_outs", o, 5'b00000); chk("mr_after_state", bus.state, 0);

      // memory stall beats load-use
      nxt(); load_use(5'd9, 5'd9, 5'd0); bus.mem_req = 1'b1;
      smp(); chk("prio_mem_lu", o, 5'b11100);
      nxt(); idle();
      smp(); chk("prio_rel_outs", o, 5'b00000);
      nxt();
      smp(); chk("prio_rel_state", bus.state, 0);

      // redirect under multi-cycle stall is deferred
      nxt(); bus.exe_valid = 1'b1; bus.exe_mc_start = 1'b1; bus.redirect = 1'b1;
      smp(); chk("mcr_stall", o, 5'b11100);
      nxt(); bus.redirect = 1'b0; bus.mc_done = 1'b1;
      smp(); chk("mcr_flush", o, 5'b00011); chk("mcr_state", bus.state, 1);
      nxt(); idle();
      smp(); chk("mcr_after", o, 5'b00000); chk("mcr_after_state", bus.state, 0);

      // reset in the middle of MC_WAIT
      nxt(); bus.exe_valid = 1'b1; bus.exe_mc_start = 1'b1;
      smp(); chk("rmc_run", bus.state, 0);
      nxt();
      smp(); chk("rmc_wait", bus.state, 1);
      nxt(); rst = 1'b0;
      smp(); chk("rmc_rst_outs", o, 5'b00011);
      nxt();
      smp(); chk("rmc_state", bus.state, 0); chk("rmc_outs", o, 5'b00011);
      chk("rmc_to", bus.mc_timeout, 0);
      nxt(); rst = 1'b1; idle();
      smp(); chk("rmc_rel_state", bus.state, 0); chk("rmc_rel_outs", o, 5'b00000);

`ifdef PIPE_CTRL_PERF_EN
      chk("perf_clr_s", perf_s, 0); chk("perf_clr_f", perf_f, 0);
      nxt(); bus.mem_req = 1'b1;
      nxt();
      nxt(); bus.mem_req = 1'b0; bus.redirect = 1'b1;
      nxt(); idle();
      smp(); chk("perf_stall", perf_s, 2); chk("perf_flush", perf_f, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
